// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side and UART-side signal bundle for uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        tx_data;
   logic              tx_wr;
   logic              tx_busy;
   logic [IDW-1:0]    grant_id;
   logic              lock_active;
   logic              timeout_pulse;

   // master: requesters plus the uart; slave: the arbiter itself
   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_data, tx_wr, grant_id, lock_active, timeout_pulse
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_data, tx_wr, grant_id, lock_active, timeout_pulse
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locking arbiter sharing one UART transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
   parameter int NREQ         = 4,
   parameter int IDW          = 2,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  wire logic        clk,
   input  wire logic        reset,
   uart_tx_arbiter_if.slave bus
);

   localparam bit          c_tmo_en   = (LOCK_TIMEOUT > 0);
   localparam logic [15:0] c_tmo_last = (LOCK_TIMEOUT > 0) ? 16'(LOCK_TIMEOUT - 1) : 16'd0;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t         state_q,     state_d;
   logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;
   logic [IDW-1:0] owner_q,     owner_d;
   logic           lock_q,      lock_d;
   logic [15:0]    tmo_cnt_q,   tmo_cnt_d;
   logic [7:0]     tx_data_q,   tx_data_d;
   logic           tx_wr_q,     tx_wr_d;
   logic [IDW-1:0] grant_q,     grant_d;
   logic           tmo_pulse_q, tmo_pulse_d;

   logic [IDW-1:0]  w_sel;
   logic            w_sel_ok;
   logic            w_owner_valid;
   logic [7:0]      w_sel_data;
   logic            w_sel_last;
   logic            w_accept;
   logic [NREQ-1:0] w_ready;
   int              w_idx;

   function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] id);
      f_next = (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
   endfunction

   always_comb begin
      w_owner_valid = 1'b0;
      w_sel         = '0;
      w_sel_ok      = 1'b0;
      w_idx         = 0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_q == IDW'(i) && bus.req_valid[i]) begin
            w_owner_valid = 1'b1;
         end
      end
      if (lock_q) begin
         w_sel    = owner_q;
         w_sel_ok = w_owner_valid;
      end else begin
         // Walk the ring backwards so the candidate nearest rr_ptr is written last.
         for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(rr_ptr_q) + k;
            if (w_idx >= NREQ) begin
               w_idx = w_idx - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
               if (i == w_idx && bus.req_valid[i]) begin
                  w_sel    = IDW'(i);
                  w_sel_ok = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      w_sel_data = '0;
      w_sel_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_sel == IDW'(i)) begin
            w_sel_data = bus.req_data[8*i +: 8];
            w_sel_last = bus.req_last[i];
         end
      end
   end

   // Gated by reset so no requester sees ready while the block is held in reset.
   assign w_accept = !reset && (state_q == IDLE) && !bus.tx_busy && w_sel_ok;

   always_comb begin
      w_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_ready[i] = w_accept && (w_sel == IDW'(i));
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      lock_d      = lock_q;
      tmo_cnt_d   = tmo_cnt_q;
      tx_data_d   = tx_data_q;
      tx_wr_d     = 1'b0;
      grant_d     = grant_q;
      tmo_pulse_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (w_accept) begin
               tx_data_d = w_sel_data;
               tx_wr_d   = 1'b1;
               grant_d   = w_sel;
               state_d   = WAIT_BUSY;
               if (w_sel_last) begin
                  lock_d   = 1'b0;
                  rr_ptr_d = f_next(w_sel);
               end else begin
                  lock_d  = 1'b1;
                  owner_d = w_sel;
               end
            end
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An accept while locked implies the owner is valid, so it never meets a timeout.
      if (!lock_q || w_owner_valid || w_accept) begin
         tmo_cnt_d = '0;
      end else if (c_tmo_en && state_q == IDLE) begin
         if (tmo_cnt_q >= c_tmo_last) begin
            lock_d      = 1'b0;
            rr_ptr_d    = f_next(owner_q);
            tmo_pulse_d = 1'b1;
            tmo_cnt_d   = '0;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         lock_q      <= 1'b0;
         tmo_cnt_q   <= '0;
         tx_data_q   <= '0;
         tx_wr_q     <= 1'b0;
         grant_q     <= '0;
         tmo_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         lock_q      <= lock_d;
         tmo_cnt_q   <= tmo_cnt_d;
         tx_data_q   <= tx_data_d;
         tx_wr_q     <= tx_wr_d;
         grant_q     <= grant_d;
         tmo_pulse_q <= tmo_pulse_d;
      end
   end

   assign bus.req_ready     = w_ready;
   assign bus.tx_data       = tx_data_q;
   assign bus.tx_wr         = tx_wr_q;
   assign bus.grant_id      = grant_q;
   assign bus.lock_active   = lock_q;
   assign bus.timeout_pulse = tmo_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Scoreboard bench for uart_tx_arbiter with a transaction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int NREQ         = 4;
   localparam int IDW          = 2;
   localparam int LOCK_TIMEOUT = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   uart_tx_arbiter #(
      .NREQ         (NREQ),
      .IDW          (IDW),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // uart: raises busy the cycle after tx_wr and holds it for one frame
   int   uart_cnt   = 0;
   logic force_busy = 1'b0;
   always @(posedge clk) begin
      if (bus.tx_wr === 1'b1)
         uart_cnt <= int'($urandom_range(4, 8));
      else if (uart_cnt > 0)
         uart_cnt <= uart_cnt - 1;
   end
   assign bus.tx_busy = (uart_cnt != 0) || force_busy;

   typedef struct {
      int         id;
      logic [7:0] data;
      bit         lock;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests     = 0;
   int   n_fail      = 0;
   bit   tmo_allowed = 1'b0;

   // reference model: next round-robin start, lock flag, owner
   int m_rr     = 0;
   bit m_locked = 1'b0;
   int m_owner  = 0;

   function automatic int model_pick(input logic [NREQ-1:0] v);
      if (m_locked) return v[m_owner] ? m_owner : -1;
      for (int k = 0; k < NREQ; k++) begin
         if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_timeout();
      m_locked = 1'b0;
      m_rr     = (m_owner + 1) % NREQ;
   endtask

   function automatic logic [8*NREQ-1:0] pack4(input logic [7:0] b0, b1, b2, b3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic issue(input logic [NREQ-1:0] v, input logic [8*NREQ-1:0] d,
                        input logic [NREQ-1:0] l, output int waited);
      int              g;
      exp_t            e;
      logic [NREQ-1:0] rdy;
      logic [NREQ-1:0] exp_rdy;
      waited = 0;
      g = model_pick(v);
      if (g < 0) return;
      e.id   = g;
      e.data = d[8*g +: 8];
      e.lock = !l[g];
      exp_q.push_back(e);
      if (l[g]) begin
         m_locked = 1'b0;
         m_rr     = (g + 1) % NREQ;
      end else begin
         m_locked = 1'b1;
         m_owner  = g;
      end
      exp_rdy    = '0;
      exp_rdy[g] = 1'b1;
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = l;
      #1;
      rdy = bus.req_valid & bus.req_ready;
      while (rdy == '0 && waited < 200) begin
         @(negedge clk);
         rdy = bus.req_valid & bus.req_ready;
         waited++;
      end
      n_tests++;
      if (rdy != exp_rdy) begin
         n_fail++;
         $display("FAIL accept_sel: ready&valid=%b expected=%b (waited %0d)", rdy, exp_rdy, waited);
         if (rdy == '0) void'(exp_q.pop_back());
      end
      if (rdy != '0) @(posedge clk);
      #1;
      bus.req_valid = '0;
   endtask

   task automatic wait_busy(input logic level, input string tag);
      int k;
      k = 0;
      @(negedge clk);
      while (bus.tx_busy !== level && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (bus.tx_busy !== level) begin
         n_fail++;
         $display("FAIL %s: tx_busy=%b required=%b within 40 cycles", tag, bus.tx_busy, level);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_tests++;
      if (bus.tx_wr !== 1'b0 || bus.tx_data !== 8'h00 || bus.grant_id !== '0 ||
          bus.lock_active !== 1'b0 || bus.timeout_pulse !== 1'b0 || bus.req_ready !== '0) begin
         n_fail++;
         $display("FAIL %s: wr=%b data=%h id=%0d lock=%b tmo=%b ready=%b, required all zero",
                  tag, bus.tx_wr, bus.tx_data, bus.grant_id, bus.lock_active,
                  bus.timeout_pulse, bus.req_ready);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset         = 1'b1;
      bus.req_valid = '1;
      bus.req_data  = '0;
      bus.req_last  = '1;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs(tag);
      reset         = 1'b0;
      bus.req_valid = '0;
      m_rr     = 0;
      m_locked = 1'b0;
      m_owner  = 0;
      exp_q.delete();
   endtask

   // monitor: pops the scoreboard on each uart write strobe
   logic prev_wr = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (bus.tx_wr === 1'b1) begin
         n_tests++;
         if (prev_wr === 1'b1 || uart_cnt != 0) begin
            n_fail++;
            $display("FAIL wr_strobe: prev_wr=%b uart_cnt=%0d, required single strobe with uart idle",
                     prev_wr, uart_cnt);
         end
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_wr: data=%h id=%0d with empty scoreboard", bus.tx_data, bus.grant_id);
         end else begin
            e = exp_q.pop_front();
            if (bus.tx_data !== e.data || int'(bus.grant_id) != e.id || bus.lock_active !== e.lock) begin
               n_fail++;
               $display("FAIL tx_byte: got data=%h id=%0d lock=%b, expected data=%h id=%0d lock=%b",
                        bus.tx_data, bus.grant_id, bus.lock_active, e.data, e.id, e.lock);
            end
         end
      end
      if (bus.timeout_pulse === 1'b1) begin
         n_tests++;
         if (!tmo_allowed) begin
            n_fail++;
            $display("FAIL spurious_timeout: timeout_pulse=1, required 0");
         end
      end
      if (bus.req_ready !== '0) begin
         n_tests++;
         if ((bus.req_ready & ~bus.req_valid) != '0 || $countones(bus.req_ready) != 1 || bus.tx_busy) begin
            n_fail++;
            $display("FAIL ready_rule: ready=%b valid=%b busy=%b", bus.req_ready, bus.req_valid, bus.tx_busy);
         end
      end
      prev_wr <= bus.tx_wr;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1);
   end

   initial begin
      int w;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;

      do_reset("reset_state");

      // single byte from requester 2 in the first idle cycle
      issue(4'b0100, pack4(8'h00, 8'h00, 8'h41, 8'h00), 4'b0100, w);
      n_tests++;
      if (w != 0) begin
         n_fail++;
         $display("FAIL first_idle_ready: accept after %0d cycles, required 0", w);
      end
      // rr pointer now 3: with everyone valid requester 3 must win
      issue(4'b1111, pack4(8'h20, 8'h21, 8'h22, 8'h23), 4'b1111, w);

      // round robin over four always-valid requesters
      do_reset("reset_rr");
      for (int t = 0; t < 5; t++)
         issue(4'b1111, pack4(8'h10, 8'h11, 8'h12, 8'h13), 4'b1111, w);

      // locked 3-byte packet from requester 1, then requester 3
      issue(4'b1011, pack4(8'hB0, 8'hA0, 8'h00, 8'hB3), 4'b1001, w);
      issue(4'b1011, pack4(8'hB0, 8'hA1, 8'h00, 8'hB3), 4'b1001, w);
      issue(4'b1011, pack4(8'hB0, 8'hA2, 8'h00, 8'hB3), 4'b1011, w);
      issue(4'b1001, pack4(8'hB0, 8'h00, 8'h00, 8'hB3), 4'b1111, w);

      // lock timeout
      do_reset("reset_tmo");
      tmo_allowed = 1'b1;
      issue(4'b0001, pack4(8'h55, 8'h00, 8'h00, 8'h00), 4'b0000, w);
      bus.req_valid = 4'b0010;
      bus.req_data  = pack4(8'h00, 8'h66, 8'h00, 8'h00);
      bus.req_last  = 4'b0010;
      wait_busy(1'b1, "tmo_busy_hi");
      wait_busy(1'b0, "tmo_busy_lo");
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         if (j == 8) begin
            n_tests++;
            if (bus.timeout_pulse !== 1'b0) begin
               n_fail++;
               $display("FAIL tmo_early: timeout_pulse=%b after 7 idle cycles, required 0", bus.timeout_pulse);
            end
         end
      end
      n_tests++;
      if (bus.timeout_pulse !== 1'b1 || bus.lock_active !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_fire: timeout_pulse=%b lock_active=%b, required 1 and 0",
                  bus.timeout_pulse, bus.lock_active);
      end
      model_timeout();
      issue(4'b0010, pack4(8'h00, 8'h66, 8'h00, 8'h00), 4'b0010, w);
      @(negedge clk);
      n_tests++;
      if (bus.timeout_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_width: timeout_pulse=%b two cycles on, required 0", bus.timeout_pulse);
      end
      tmo_allowed = 1'b0;

      // tx_busy held high while idle
      do_reset("reset_busy");
      wait_busy(1'b0, "busy_idle");
      force_busy    = 1'b1;
      bus.req_valid = 4'b0001;
      bus.req_data  = pack4(8'h77, 8'h00, 8'h00, 8'h00);
      bus.req_last  = 4'b0001;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         n_tests++;
         if (bus.req_ready !== '0 || bus.tx_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_block: ready=%b tx_wr=%b, required 0 and 0", bus.req_ready, bus.tx_wr);
         end
      end
      @(negedge clk);
      force_busy = 1'b0;
      issue(4'b0001, pack4(8'h77, 8'h00, 8'h00, 8'h00), 4'b0001, w);
      n_tests++;
      if (w != 0) begin
         n_fail++;
         $display("FAIL busy_release: accept after %0d cycles, required 0", w);
      end

      // reset while a locked packet byte is on the line
      wait_busy(1'b0, "lockrst_idle");
      issue(4'b0100, pack4(8'h00, 8'h00, 8'hC3, 8'h00), 4'b0000, w);
      wait_busy(1'b1, "lockrst_busy");
      n_tests++;
      if (bus.lock_active !== 1'b1 || bus.grant_id !== 2'd2) begin
         n_fail++;
         $display("FAIL lock_held: lock=%b id=%0d, required 1 and 2", bus.lock_active, bus.grant_id);
      end
      do_reset("reset_mid_packet");
      issue(4'b1111, pack4(8'h80, 8'h81, 8'h82, 8'h83), 4'b1111, w);

      // randomized traffic; a locked owner always keeps its valid up
      for (int t = 0; t < 120; t++) begin
         logic [NREQ-1:0]   v;
         logic [NREQ-1:0]   l;
         logic [8*NREQ-1:0] d;
         v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         if (m_locked) v[m_owner] = 1'b1;
         l = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) d[8*i +: 8] = 8'($urandom);
         issue(v, d, l, w);
      end

      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected bytes never written, required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
